// File: rtl/kmp_dispatch_ctrl.sv
// kmp_dispatch_ctrl
// Job-level scheduler for an array of NUM_PE KMP processing elements that
// share one string/pattern buffer. A job is split into NUM_PE overlapping
// windows. Every PE whose window can hold the whole pattern is launched.
// The block then waits for all launched PEs, releases them for two cycles
// and reports the earliest match offset.
//
// Optional feature: define KMP_CTRL_TIMEOUT_EN to build a WAIT-state
// watchdog that aborts the job after TIMEOUT_CYCLES cycles.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   job_valid/job_ready  job handshake; lengths sampled on accept
//   str_last_idx         index of last string byte
//   pat_last_idx         index of last pattern byte
//   pe_input_valid       per-PE launch level
//   pe_start_idx         per-PE window start (slice k for PE k)
//   pe_process_2idx      per-PE inclusive window end
//   pe_output_valid      per-PE done indication
//   pe_match             per-PE match flag
//   pe_match_idx         per-PE match offset
//   result_valid         one-cycle result pulse
//   result_match         at least one match found
//   result_idx           earliest match offset (0 if none)
//   result_timeout       job aborted by the watchdog
module kmp_dispatch_ctrl #(
    parameter int NUM_PE         = 4,
    parameter int STR_ADDR_W     = 5,
    parameter int PAT_ADDR_W     = 3,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         job_valid,
    output logic                         job_ready,
    input  logic [STR_ADDR_W-1:0]        str_last_idx,
    input  logic [PAT_ADDR_W-1:0]        pat_last_idx,
    output logic [NUM_PE-1:0]            pe_input_valid,
    output logic [NUM_PE*STR_ADDR_W-1:0] pe_start_idx,
    output logic [NUM_PE*STR_ADDR_W-1:0] pe_process_2idx,
    input  logic [NUM_PE-1:0]            pe_output_valid,
    input  logic [NUM_PE-1:0]            pe_match,
    input  logic [NUM_PE*STR_ADDR_W-1:0] pe_match_idx,
    output logic                         result_valid,
    output logic                         result_match,
    output logic [STR_ADDR_W-1:0]        result_idx,
    output logic                         result_timeout
);

    localparam int LOG2_PE = $clog2(NUM_PE);
    localparam int WW      = STR_ADDR_W + 2;

    typedef enum logic [5:0] {
        S_IDLE     = 6'b000001,
        S_SETUP    = 6'b000010,
        S_DISPATCH = 6'b000100,
        S_WAIT     = 6'b001000,
        S_RELEASE  = 6'b010000,
        S_REPORT   = 6'b100000
    } state_t;

    state_t state_q, state_d;

    logic [STR_ADDR_W-1:0]                  strLast_q;
    logic [PAT_ADDR_W-1:0]                  patLast_q;
    logic [NUM_PE-1:0]                      mask_q, done_q, match_q;
    logic [NUM_PE-1:0][STR_ADDR_W-1:0]      matchIdx_q, startIdx_q, endIdx_q;
    logic                                   relCnt_q;

    logic [WW-1:0]                          lenW, segW, startW, endW;
    logic [NUM_PE-1:0][STR_ADDR_W-1:0]      startNext, endNext, matchIdxNext;
    logic [NUM_PE-1:0]                      maskNext, doneNext, matchNext;
    logic [STR_ADDR_W-1:0]                  firstIdx;
    logic                                   watchdogHit, timedOut, allDone;

    // Window geometry is computed from the live job inputs so the registered
    // bounds are already valid during SETUP. The extra two bits keep the
    // start+seg+pattern sums from wrapping before the clamp to the string end.
    always_comb begin
        lenW      = WW'(str_last_idx) + WW'(1);
        segW      = (lenW + WW'(NUM_PE - 1)) >> LOG2_PE;
        startW    = '0;
        endW      = '0;
        startNext = '0;
        endNext   = '0;
        maskNext  = '0;
        for (int k = 0; k < NUM_PE; k++) begin
            startW = WW'(k) * segW;
            endW   = startW + segW - WW'(1) + WW'(pat_last_idx);
            if (endW > WW'(str_last_idx)) begin
                endW = WW'(str_last_idx);
            end
            startNext[k] = startW[STR_ADDR_W-1:0];
            endNext[k]   = endW[STR_ADDR_W-1:0];
            maskNext[k]  = (startW + WW'(pat_last_idx)) <= WW'(str_last_idx);
        end
    end

    // Completion capture: only the first report from an enabled PE counts.
    always_comb begin
        doneNext     = done_q;
        matchNext    = match_q;
        matchIdxNext = matchIdx_q;
        for (int k = 0; k < NUM_PE; k++) begin
            if (pe_output_valid[k] && mask_q[k] && !done_q[k]) begin
                doneNext[k]     = 1'b1;
                matchNext[k]    = pe_match[k];
                matchIdxNext[k] = pe_match_idx[k*STR_ADDR_W +: STR_ADDR_W];
            end
        end
    end

    assign allDone = &doneNext;

    // Lowest-index matching PE wins because its window starts earliest.
    always_comb begin
        firstIdx = '0;
        for (int k = NUM_PE - 1; k >= 0; k--) begin
            if (match_q[k]) begin
                firstIdx = matchIdx_q[k];
            end
        end
    end

`ifdef KMP_CTRL_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] waitCnt_q;
    logic             timedOut_q;

    assign watchdogHit = (state_q == S_WAIT) && (waitCnt_q == CNT_W'(TIMEOUT_CYCLES));
    assign timedOut    = timedOut_q;

    // Counter is zero on the first WAIT cycle and counts every WAIT cycle.
    // A job that completes on the same cycle the watchdog fires is not
    // treated as timed out.
    always_ff @(posedge clk) begin
        if (reset) begin
            waitCnt_q  <= '0;
            timedOut_q <= 1'b0;
        end else begin
            if (state_q == S_DISPATCH) begin
                waitCnt_q <= '0;
            end else if (state_q == S_WAIT) begin
                waitCnt_q <= waitCnt_q + CNT_W'(1);
            end
            if (state_q == S_IDLE && job_valid) begin
                timedOut_q <= 1'b0;
            end else if (watchdogHit && !allDone) begin
                timedOut_q <= 1'b1;
            end
        end
    end
`else
    localparam int unusedTimeoutCycles = TIMEOUT_CYCLES;
    assign watchdogHit = 1'b0;
    assign timedOut    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (job_valid) state_d = S_SETUP;
            S_SETUP:    state_d = (WW'(patLast_q) > WW'(strLast_q)) ? S_REPORT : S_DISPATCH;
            S_DISPATCH: state_d = S_WAIT;
            S_WAIT:     if (allDone || watchdogHit) state_d = S_RELEASE;
            S_RELEASE:  if (relCnt_q) state_d = S_REPORT;
            S_REPORT:   state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Job datapath: latch geometry on accept, preset flags of disabled PEs in
    // SETUP, clear flags of enabled PEs at launch, collect results in WAIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            strLast_q  <= '0;
            patLast_q  <= '0;
            mask_q     <= '0;
            done_q     <= '0;
            match_q    <= '0;
            matchIdx_q <= '0;
            startIdx_q <= '0;
            endIdx_q   <= '0;
            relCnt_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (job_valid) begin
                        strLast_q  <= str_last_idx;
                        patLast_q  <= pat_last_idx;
                        mask_q     <= maskNext;
                        startIdx_q <= startNext;
                        endIdx_q   <= endNext;
                    end
                end
                S_SETUP: begin
                    done_q  <= ~mask_q;
                    match_q <= match_q & mask_q;
                end
                S_DISPATCH: begin
                    done_q  <= done_q & ~mask_q;
                    match_q <= match_q & ~mask_q;
                end
                S_WAIT: begin
                    done_q     <= doneNext;
                    match_q    <= matchNext;
                    matchIdx_q <= matchIdxNext;
                    relCnt_q   <= 1'b0;
                end
                S_RELEASE: relCnt_q <= ~relCnt_q;
                default: ;
            endcase
        end
    end

    assign job_ready       = (state_q == S_IDLE) && !reset;
    assign pe_input_valid  = (state_q == S_DISPATCH || state_q == S_WAIT) ? mask_q : '0;
    assign pe_start_idx    = startIdx_q;
    assign pe_process_2idx = endIdx_q;
    assign result_valid    = (state_q == S_REPORT);
    assign result_match    = result_valid && (|match_q) && !timedOut;
    assign result_idx      = result_match ? firstIdx : '0;
    assign result_timeout  = result_valid && timedOut;

endmodule

// File: tb/tb_kmp_dispatch_ctrl.sv
// tb_kmp_dispatch_ctrl
// Directed bench for kmp_dispatch_ctrl with NUM_PE=4, STR_ADDR_W=5,
// PAT_ADDR_W=3. Inputs change and outputs are sampled on the falling edge.
// The watchdog scenario is compiled only with KMP_CTRL_TIMEOUT_EN.
module tb_kmp_dispatch_ctrl;

    localparam int NUM_PE = 4;
    localparam int SW     = 5;
    localparam int PW     = 3;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 job_valid;
    logic                 job_ready;
    logic [SW-1:0]        str_last_idx;
    logic [PW-1:0]        pat_last_idx;
    logic [NUM_PE-1:0]    pe_input_valid;
    logic [NUM_PE*SW-1:0] pe_start_idx;
    logic [NUM_PE*SW-1:0] pe_process_2idx;
    logic [NUM_PE-1:0]    pe_output_valid;
    logic [NUM_PE-1:0]    pe_match;
    logic [NUM_PE*SW-1:0] pe_match_idx;
    logic                 result_valid;
    logic                 result_match;
    logic [SW-1:0]        result_idx;
    logic                 result_timeout;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    kmp_dispatch_ctrl #(
        .NUM_PE(NUM_PE), .STR_ADDR_W(SW), .PAT_ADDR_W(PW), .TIMEOUT_CYCLES(20)
    ) dut (
        .clk(clk), .reset(reset),
        .job_valid(job_valid), .job_ready(job_ready),
        .str_last_idx(str_last_idx), .pat_last_idx(pat_last_idx),
        .pe_input_valid(pe_input_valid),
        .pe_start_idx(pe_start_idx), .pe_process_2idx(pe_process_2idx),
        .pe_output_valid(pe_output_valid), .pe_match(pe_match),
        .pe_match_idx(pe_match_idx),
        .result_valid(result_valid), .result_match(result_match),
        .result_idx(result_idx), .result_timeout(result_timeout)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    // Offer a job for one cycle; returns at the falling edge of SETUP.
    task automatic applyStimulus(input logic [SW-1:0] s, input logic [PW-1:0] p);
        job_valid    = 1'b1;
        str_last_idx = s;
        pat_last_idx = p;
        tick;
        job_valid = 1'b0;
    endtask

    task automatic drivePe(input logic [3:0] v, input logic [3:0] m, input logic [19:0] idx);
        pe_output_valid = v;
        pe_match        = m;
        pe_match_idx    = idx;
    endtask

    initial begin
        reset        = 1'b1;
        job_valid    = 1'b0;
        str_last_idx = '0;
        pat_last_idx = '0;
        drivePe(4'b0, 4'b0, 20'b0);
        tick;
        tick;
        checkOutput("rst_ready",  32'(job_ready), 32'd0);
        checkOutput("rst_piv",    32'(pe_input_valid), 32'd0);
        checkOutput("rst_rv",     32'(result_valid), 32'd0);
        checkOutput("rst_start",  32'(pe_start_idx), 32'd0);
        checkOutput("rst_end",    32'(pe_process_2idx), 32'd0);
        checkOutput("rst_match",  32'(result_match), 32'd0);
        checkOutput("rst_idx",    32'(result_idx), 32'd0);
        checkOutput("rst_tmo",    32'(result_timeout), 32'd0);
        reset = 1'b0;
        tick;
        checkOutput("post_rst_ready", 32'(job_ready), 32'd1);

        // Single match at offset 9 in PE2's window
        applyStimulus(5'd15, 3'd2);
        checkOutput("t1_start", 32'(pe_start_idx),    32'({5'd12, 5'd8, 5'd4, 5'd0}));
        checkOutput("t1_end",   32'(pe_process_2idx), 32'({5'd15, 5'd13, 5'd9, 5'd5}));
        checkOutput("t1_setup_piv", 32'(pe_input_valid), 32'd0);
        checkOutput("t1_setup_ready", 32'(job_ready), 32'd0);
        tick;
        checkOutput("t1_disp_piv", 32'(pe_input_valid), 32'b1111);
        job_valid    = 1'b1;
        str_last_idx = 5'd7;
        pat_last_idx = 3'd3;
        tick;
        checkOutput("t1_wait_piv", 32'(pe_input_valid), 32'b1111);
        job_valid = 1'b0;
        drivePe(4'b0001, 4'b0000, 20'b0);
        tick;
        drivePe(4'b1100, 4'b0100, {5'd0, 5'd9, 5'd0, 5'd0});
        tick;
        checkOutput("t1_ignore_job", 32'(pe_start_idx), 32'({5'd12, 5'd8, 5'd4, 5'd0}));
        checkOutput("t1_hold_piv", 32'(pe_input_valid), 32'b1111);
        drivePe(4'b0110, 4'b0000, {5'd0, 5'd3, 5'd0, 5'd0});
        tick;
        drivePe(4'b0, 4'b0, 20'b0);
        checkOutput("t1_rel1_piv", 32'(pe_input_valid), 32'd0);
        checkOutput("t1_rel1_rv",  32'(result_valid), 32'd0);
        tick;
        checkOutput("t1_rel2_piv", 32'(pe_input_valid), 32'd0);
        checkOutput("t1_rel2_rv",  32'(result_valid), 32'd0);
        tick;
        checkOutput("t1_rv",    32'(result_valid), 32'd1);
        checkOutput("t1_match", 32'(result_match), 32'd1);
        checkOutput("t1_idx",   32'(result_idx), 32'd9);
        checkOutput("t1_tmo",   32'(result_timeout), 32'd0);
        tick;
        checkOutput("t1_ready",    32'(job_ready), 32'd1);
        checkOutput("t1_rv_off",   32'(result_valid), 32'd0);
        checkOutput("t1_idx_off",  32'(result_idx), 32'd0);

        // Matches at 6 (PE1) and 11 (PE2): earliest wins
        applyStimulus(5'd15, 3'd2);
        tick;
        tick;
        drivePe(4'b1111, 4'b0110, {5'd0, 5'd11, 5'd6, 5'd0});
        tick;
        drivePe(4'b0, 4'b0, 20'b0);
        checkOutput("t2_rel1_rv", 32'(result_valid), 32'd0);
        tick;
        checkOutput("t2_rel2_rv", 32'(result_valid), 32'd0);
        tick;
        checkOutput("t2_rv",    32'(result_valid), 32'd1);
        checkOutput("t2_match", 32'(result_match), 32'd1);
        checkOutput("t2_idx",   32'(result_idx), 32'd6);
        tick;
        checkOutput("t2_ready", 32'(job_ready), 32'd1);

        // Short string: PE3 disabled, its reports ignored
        applyStimulus(5'd7, 3'd3);
        checkOutput("t3_start", 32'(pe_start_idx),    32'({5'd6, 5'd4, 5'd2, 5'd0}));
        checkOutput("t3_end",   32'(pe_process_2idx), 32'({5'd7, 5'd7, 5'd6, 5'd4}));
        tick;
        checkOutput("t3_disp_piv", 32'(pe_input_valid), 32'b0111);
        tick;
        checkOutput("t3_wait_piv", 32'(pe_input_valid), 32'b0111);
        checkOutput("t3_wait_rv",  32'(result_valid), 32'd0);
        tick;
        checkOutput("t3_hold_piv", 32'(pe_input_valid), 32'b0111);
        drivePe(4'b1111, 4'b1000, {5'd6, 5'd0, 5'd0, 5'd0});
        tick;
        drivePe(4'b0, 4'b0, 20'b0);
        checkOutput("t3_rel_piv", 32'(pe_input_valid), 32'd0);
        tick;
        tick;
        checkOutput("t3_rv",    32'(result_valid), 32'd1);
        checkOutput("t3_match", 32'(result_match), 32'd0);
        checkOutput("t3_idx",   32'(result_idx), 32'd0);
        tick;
        checkOutput("t3_ready", 32'(job_ready), 32'd1);

        // Pattern longer than string: straight to REPORT
        applyStimulus(5'd3, 3'd5);
        checkOutput("t4_setup_piv", 32'(pe_input_valid), 32'd0);
        checkOutput("t4_setup_rv",  32'(result_valid), 32'd0);
        tick;
        checkOutput("t4_rv",    32'(result_valid), 32'd1);
        checkOutput("t4_match", 32'(result_match), 32'd0);
        checkOutput("t4_piv",   32'(pe_input_valid), 32'd0);
        tick;
        checkOutput("t4_ready", 32'(job_ready), 32'd1);
        checkOutput("t4_rv_off", 32'(result_valid), 32'd0);

        // Reset during WAIT, then a normal job
        applyStimulus(5'd15, 3'd2);
        tick;
        tick;
        drivePe(4'b0001, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd2});
        reset = 1'b1;
        tick;
        checkOutput("t5_rst_ready", 32'(job_ready), 32'd0);
        checkOutput("t5_rst_piv",   32'(pe_input_valid), 32'd0);
        checkOutput("t5_rst_rv",    32'(result_valid), 32'd0);
        checkOutput("t5_rst_start", 32'(pe_start_idx), 32'd0);
        reset = 1'b0;
        drivePe(4'b0, 4'b0, 20'b0);
        tick;
        checkOutput("t5_ready", 32'(job_ready), 32'd1);
        checkOutput("t5_rv",    32'(result_valid), 32'd0);
        tick;
        checkOutput("t5_rv2",   32'(result_valid), 32'd0);
        applyStimulus(5'd15, 3'd2);
        tick;
        checkOutput("t5_disp_piv", 32'(pe_input_valid), 32'b1111);
        tick;
        drivePe(4'b1111, 4'b1000, {5'd13, 5'd0, 5'd0, 5'd0});
        tick;
        drivePe(4'b0, 4'b0, 20'b0);
        tick;
        tick;
        checkOutput("t5_res_rv",    32'(result_valid), 32'd1);
        checkOutput("t5_res_match", 32'(result_match), 32'd1);
        checkOutput("t5_res_idx",   32'(result_idx), 32'd13);
        tick;
        checkOutput("t5_res_ready", 32'(job_ready), 32'd1);

`ifdef KMP_CTRL_TIMEOUT_EN
        // Watchdog: PE2 never completes; timeout pulse 23 cycles after WAIT entry
        applyStimulus(5'd15, 3'd2);
        tick;
        tick;
        drivePe(4'b1011, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd1});
        tick;
        drivePe(4'b0, 4'b0, 20'b0);
        for (int i = 1; i < 23; i++) begin
            checkOutput("t6_no_rv", 32'(result_valid), 32'd0);
            tick;
        end
        checkOutput("t6_rv",    32'(result_valid), 32'd1);
        checkOutput("t6_tmo",   32'(result_timeout), 32'd1);
        checkOutput("t6_match", 32'(result_match), 32'd0);
        checkOutput("t6_idx",   32'(result_idx), 32'd0);
        tick;
        checkOutput("t6_ready", 32'(job_ready), 32'd1);
        checkOutput("t6_tmo_off", 32'(result_timeout), 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/kmp_dispatch_ctrl.md
# kmp_dispatch_ctrl

Job-level scheduler for an array of `NUM_PE` KMP processing elements sharing one string/pattern buffer. The block accepts a search job, splits the string into `NUM_PE` overlapping windows, and launches every useful PE with its window bounds. It then collects per-PE completions, releases the PEs, and reports the earliest match offset. It sits between the job front-end and the PE array; the string, pattern and failure-function buses go to the PEs directly.

## Interface
- `NUM_PE`, default 4: number of PEs. Must be a power of 2, ≥2.
- `STR_ADDR_W`, default 5: string index width.
- `PAT_ADDR_W`, default 3: pattern index width.
- `TIMEOUT_CYCLES`, default 1023: watchdog limit. Used only with `KMP_CTRL_TIMEOUT_EN`.
- Clocking and reset: reset reset, synchronous, active-high; clock clk.
- `clk`, in, 1: clock.
- `reset`, in, 1: synchronous active-high reset.
- `job_valid`, in, 1: a job is offered.
- `job_ready`, out, 1: the controller can accept a job.
- `str_last_idx`, in, STR_ADDR_W: index of the last string byte. Sampled on accept.
- `pat_last_idx`, in, PAT_ADDR_W: index of the last pattern byte. Sampled on accept.
- `pe_input_valid`, out, NUM_PE: per-PE launch level.
- `pe_start_idx`, out, NUM_PE*STR_ADDR_W: per-PE window start. PE k uses slice k.
- `pe_process_2idx`, out, NUM_PE*STR_ADDR_W: per-PE inclusive window end.
- `pe_output_valid`, in, NUM_PE: per-PE done indication.
- `pe_match`, in, NUM_PE: per-PE match flag. Qualified by `pe_output_valid`.
- `pe_match_idx`, in, NUM_PE*STR_ADDR_W: per-PE match offset.
- `result_valid`, out, 1: one-cycle result pulse.
- `result_match`, out, 1: at least one match was found.
- `result_idx`, out, STR_ADDR_W: earliest match offset. 0 when there is no match.
- `result_timeout`, out, 1: the job was aborted by the watchdog.

## Operation
- **FSM states:** IDLE, SETUP, DISPATCH, WAIT, RELEASE, REPORT. All states are one-hot.
- **IDLE:** `job_ready`=1. On `job_valid`, latch the lengths and go to SETUP.
- **SETUP (1 cycle):**
  - len = str_last_idx+1, computed at STR_ADDR_W+1 bits.
  - seg_len = (len + NUM_PE − 1) >> log2(NUM_PE).
  - start_k = k·seg_len.
  - end_k = min(start_k + seg_len − 1 + pat_last_idx, str_last_idx).
  - All window arithmetic uses STR_ADDR_W+2 bits before clamping.
  - PE k is enabled iff start_k + pat_last_idx ≤ str_last_idx.
  - Disabled PEs have their done flag preset and their match flag cleared.
  - If pat_last_idx > str_last_idx, no PE is enabled. Go straight to REPORT with result_match=0.
- **DISPATCH (1 cycle):** drive `pe_input_valid`=enable mask. Clear the sticky done and match flags of the enabled PEs.
- **WAIT:**
  - `pe_input_valid` holds at the enable mask.
  - When `pe_output_valid[k]` is seen, set done[k] and latch `pe_match[k]` and `pe_match_idx[k]`.
  - Once all done flags are set, go to RELEASE.
- **RELEASE (2 cycles):** `pe_input_valid`=0, so every PE returns to its idle state before a new launch.
- **REPORT (1 cycle):**
  - `result_valid`=1.
  - result_idx comes from the lowest-index PE with a latched match. Lower windows start earlier, so this is the earliest occurrence.
  - Return to IDLE.
- **Window outputs:** `pe_start_idx` and `pe_process_2idx` are registered. They stay stable from SETUP until the next accept.
- **Done flags:** a `pe_output_valid` on a PE that is disabled, or already done, is ignored.

## Timing
- Accept occurs in cycle T. SETUP is T+1. DISPATCH raises `pe_input_valid` at T+2.
- After the last PE completes in cycle D: RELEASE is D+1..D+2, `result_valid` is at D+3, and `job_ready`=1 at D+4.
- Reset values: `job_ready`=0 during reset and 1 from the first cycle after it. All other outputs are 0.
- Reset asserted in any state forces IDLE and `pe_input_valid`=0 on the next edge. No result is emitted for the aborted job.
- `job_valid` is ignored outside IDLE.
- Result outputs are valid only while `result_valid`=1. Otherwise they are 0.

## Configuration
- `KMP_CTRL_TIMEOUT_EN` defined:
  - A counter clears on entry to WAIT and increments every WAIT cycle.
  - When it reaches TIMEOUT_CYCLES, go to RELEASE.
  - REPORT then gives result_timeout=1, result_match=0 and result_idx=0.
- `KMP_CTRL_TIMEOUT_EN` undefined: no counter is built, `result_timeout` is tied to 0, and WAIT exits only when all PEs are done.

## Test plan
- **Match in one window:** str_last_idx=15, pat_last_idx=2, NUM_PE=4, match at offset 9.
  - Required windows: starts 0/4/8/12, ends 5/9/13/15.
  - Required mask: 4'b1111.
  - Required result: result_match=1, result_idx=9.
- **Two matches in overlapping windows:** matches at offsets 6 and 11. Required: result_idx=6 (PE1 wins over PE2).
- **Short string disables PEs:** str_last_idx=7, pat_last_idx=3.
  - Required: seg_len=2, starts 0/2/4/6, mask 4'b0111 (PE3 disabled).
  - Required: PE3 launch line stays 0. With no match, result_match=0 and result_idx=0.
- **Pattern longer than string:** pat_last_idx=5, str_last_idx=3. Required: no PE launches, `result_valid` at T+2 with result_match=0.
- **Reset mid-job:** reset in WAIT with PEs running. Required: all outputs 0 the next cycle, no `result_valid`, and the next job completes normally.
- **Watchdog (macro defined):** TIMEOUT_CYCLES=20 and PE2 never completes. Required: result_timeout=1 twenty-three cycles after WAIT entry, and `job_ready` returns.
